// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between EX decode and the HI/LO mul/div sequencer
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  stall, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer for HI/LO (MULDIV_FAST_MUL_EN: single-cycle multiply)
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic     i_clk,
    input  logic     i_rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

`ifdef MULDIV_FAST_MUL_EN
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_SIGN, S_DONE, S_MULF} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;
`endif

    state_t             r_state;
    state_t             w_next;
    state_t             w_accept_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_div;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_idle_or_done;
    logic               w_accept;
    logic               w_signed_op;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_shl;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_res;
    logic               w_busy;

    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept       = w_idle_or_done && bus.start && !bus.flush;
    assign w_signed_op    = !bus.op[0];

    // Signed ops iterate on magnitudes; 0x80..0 negates to itself and is read as unsigned.
    assign w_abs_a = (w_signed_op && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    assign w_abs_b = (w_signed_op && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_step = {w_add, r_acc[WIDTH-1:1]};

    // Restoring divide: {remainder, dividend/quotient}; a zero divisor always "fits".
    assign w_shl      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = (w_shl >= {1'b0, r_b});
    assign w_sub      = w_shl[WIDTH-1:0] - r_b;
    assign w_div_step = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                             : {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    always_comb begin
        w_res = r_acc;
        if (r_div) begin
            w_res[WIDTH-1:0]       = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_res[2*WIDTH-1:WIDTH] = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end else if (r_neg_a ^ r_neg_b) begin
            w_res = -r_acc;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_mag;
    logic [2*WIDTH-1:0] w_fast_res;
    assign w_fast_mag = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    assign w_fast_res = (r_neg_a ^ r_neg_b) ? -w_fast_mag : w_fast_mag;
    assign w_accept_state = bus.op[1] ? S_CALC : S_MULF;
    assign w_busy = (r_state == S_CALC) || (r_state == S_SIGN) || (r_state == S_MULF);
`else
    assign w_accept_state = S_CALC;
    assign w_busy = (r_state == S_CALC) || (r_state == S_SIGN);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = w_accept ? w_accept_state : S_IDLE;
            S_CALC:         if (r_cnt == CW'(WIDTH-1)) w_next = S_SIGN;
            S_SIGN:         w_next = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            S_MULF:         w_next = S_DONE;
`endif
            default:        w_next = S_IDLE;
        endcase
        if (bus.flush) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_div   <= 1'b0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_DONE);
            if (w_accept) begin
                r_cnt   <= '0;
                r_a     <= w_abs_a;
                r_b     <= w_abs_b;
                r_neg_a <= w_signed_op && bus.src_a[WIDTH-1];
                r_neg_b <= w_signed_op && bus.src_b[WIDTH-1];
                r_div   <= bus.op[1];
                r_acc   <= bus.op[1] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + CW'(1);
                r_acc <= r_div ? w_div_step : w_mul_step;
            end
            if (r_state == S_SIGN && !bus.flush) begin
                {r_hi, r_lo} <= w_res;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (r_state == S_MULF && !bus.flush) begin
                {r_hi, r_lo} <= w_fast_res;
            end
`endif
        end
    end

    assign bus.stall = !i_rst && ((w_idle_or_done && bus.start) || w_busy);
    assign bus.done  = r_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed and random checks of muldiv_ctrl against an arithmetic model
module tb_muldiv_ctrl;
    localparam int W        = 32;
    localparam int LAT_ITER = W + 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_ctrl #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
        if (!op[1]) return 2;
`endif
        return LAT_ITER;
    endfunction

    // Returns {hi, lo} from plain arithmetic on the operands.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [31:0]     ma, mb, q, r;
        case (op)
            2'd0: begin
                sa = $signed(a);
                sb = $signed(b);
                return 64'(sa * sb);
            end
            2'd1: begin
                ua = a;
                ub = b;
                return 64'(ua * ub);
            end
            default: begin
                ma = (op == 2'd2 && a[31]) ? 32'(0 - a) : a;
                mb = (op == 2'd2 && b[31]) ? 32'(0 - b) : b;
                if (mb == 0) begin
                    q = 32'hFFFF_FFFF;
                    r = ma;
                end else begin
                    q = ma / mb;
                    r = ma % mb;
                end
                if (op == 2'd2) begin
                    if (a[31] ^ b[31]) q = 32'(0 - q);
                    if (a[31])         r = 32'(0 - r);
                end
                return {r, q};
            end
        endcase
    endfunction

    // Caller has start raised in cycle 0; returns the cycle in which done appears (0 on timeout).
    task automatic wait_done(input string tag, output int lat);
        int low_stall;
        low_stall = 0;
        lat = 0;
        step();
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        for (int c = 1; c <= 100; c++) begin
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            if (bus.stall !== 1'b1) low_stall++;
            if (c == 5) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom);
            end
            if (c == 6) bus.start = 1'b0;
            step();
        end
        chk({tag, ".stall_busy_lows"}, 64'(low_stall), 64'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int lat;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        #1;
        chk({tag, ".stall_c0"}, 64'(bus.stall), 64'd1);
        wait_done(tag, lat);
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat(op)));
        chk({tag, ".hi"}, 64'(bus.hi), 64'(eh));
        chk({tag, ".lo"}, 64'(bus.lo), 64'(el));
        chk({tag, ".stall_done"}, 64'(bus.stall), 64'd0);
        step();
        chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, hits;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] exp_hl;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.flush = 1'b0;
        step();
        step();
        bus.start = 1'b1;
        #1;
        chk("reset.stall", 64'(bus.stall), 64'd0);
        chk("reset.done", 64'(bus.done), 64'd0);
        chk("reset.hi", 64'(bus.hi), 64'd0);
        chk("reset.lo", 64'(bus.lo), 64'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        step();

        run("t1_divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run("t2_div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("t2_div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run("t3_mult", 2'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("t3_multu", 2'd1, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);
        run("t4_divu_z", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        exp_hl = model(2'd2, 32'hFFFF_FFF6, 32'd0);
        run("t4_div_z", 2'd2, 32'hFFFF_FFF6, 32'd0, exp_hl[63:32], exp_hl[31:0]);

        // Flush in cycle 10 of a DIV discards it and keeps the previous HI/LO.
        run("t5_divu", 2'd3, 32'd9, 32'd4, 32'd1, 32'd2);
        bus.op    = 2'd2;
        bus.src_a = 32'd50;
        bus.src_b = 32'd5;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        hits = 0;
        for (int c = 1; c < 10; c++) begin
            if (bus.done === 1'b1) hits++;
            step();
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("t5_flush.done_seen", 64'(hits), 64'd0);
        chk("t5_flush.stall", 64'(bus.stall), 64'd0);
        chk("t5_flush.done", 64'(bus.done), 64'd0);
        chk("t5_flush.hi", 64'(bus.hi), 64'd1);
        chk("t5_flush.lo", 64'(bus.lo), 64'd2);
        run("t5_multu", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12);

        // Second start held during the DONE cycle is accepted at that edge.
        bus.op    = 2'd1;
        bus.src_a = 32'd6;
        bus.src_b = 32'd7;
        bus.start = 1'b1;
        #1;
        wait_done("t6_first", lat);
        chk("t6_first.latency", 64'(lat), 64'(exp_lat(2'd1)));
        chk("t6_first.lo", 64'(bus.lo), 64'd42);
        bus.op    = 2'd3;
        bus.src_a = 32'd7;
        bus.src_b = 32'd2;
        bus.start = 1'b1;
        #1;
        chk("t6_b2b.stall_done", 64'(bus.stall), 64'd1);
        step();
        bus.start = 1'b0;
        chk("t6_b2b.accepted_stall", 64'(bus.stall), 64'd1);
        chk("t6_b2b.done_low", 64'(bus.done), 64'd0);
        repeat (15) step();
        rst       = 1'b1;
        bus.start = 1'b1;
        step();
        chk("t6_rst.stall", 64'(bus.stall), 64'd0);
        chk("t6_rst.done", 64'(bus.done), 64'd0);
        chk("t6_rst.hi", 64'(bus.hi), 64'd0);
        chk("t6_rst.lo", 64'(bus.lo), 64'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        step();
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1 || bus.stall === 1'b1) hits++;
            step();
        end
        chk("t6_rst.quiet_after", 64'(hits), 64'd0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(0, 3));
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            exp_hl = model(rop, ra, rb);
            run($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, exp_hl[63:32], exp_hl[31:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
